multicycle_sequencer: RTL and testbench

//  Multi-cycle stage sequencer for the RISC datapath. Steps each instruction through

---
 rtl/multicycle_sequencer.sv | 168 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB stage sequencer with interrupt entry and HALT
// Optional cycle/retire counters are built when PERF_CNT_EN is defined.
module multicycle_sequencer #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        mem_access,
    input  logic        reg_write,
    input  logic        halt,
    input  logic        rfe,
    output logic        ir_load,
    output logic        updPC,
    output logic        mem_stage,
    output logic        wr_stage,
    output logic        pc_sel_vec,
    output logic        save_epc,
    output logic        int_ack,
    output logic        instr_done,
    output logic        halted,
    output logic [2:0]  stage,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_INTR   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] MEM_LOAD = 4'(MEM_WAIT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_ie;
    logic       r_int_pend;
    logic [3:0] r_mem_cnt;
    logic       w_retire;
    logic       w_mem_enter;
    logic       w_int_req;

    // A request raised in the deciding cycle itself counts as pending.
    assign w_int_req = r_int_pend | INT;

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_mem_enter = 1'b0;
        ir_load     = 1'b0;
        updPC       = 1'b0;
        mem_stage   = 1'b0;
        wr_stage    = 1'b0;
        pc_sel_vec  = 1'b0;
        save_epc    = 1'b0;
        int_ack     = 1'b0;
        instr_done  = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_load = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: w_next = halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (mem_access) begin
                    w_next      = S_MEM;
                    w_mem_enter = 1'b1;
                end else if (reg_write) begin
                    w_next = S_WB;
                end else begin
                    w_retire = 1'b1;
                end
            end
            S_MEM: begin
                mem_stage = 1'b1;
                if (r_mem_cnt == 4'd0) begin
                    if (reg_write) w_next = S_WB;
                    else           w_retire = 1'b1;
                end
            end
            S_WB: begin
                wr_stage = 1'b1;
                w_retire = 1'b1;
            end
            S_INTR: begin
                save_epc   = 1'b1;
                pc_sel_vec = 1'b1;
                updPC      = 1'b1;
                int_ack    = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (w_int_req && r_ie) w_next = S_INTR;
            end
            default: w_next = S_FETCH;
        endcase

        // rfe re-enables interrupts in time for its own retire decision.
        if (w_retire) begin
            updPC      = 1'b1;
            instr_done = 1'b1;
            w_next     = (w_int_req && (r_ie || rfe)) ? S_INTR : S_FETCH;
        end

        if (rst) begin
            ir_load    = 1'b0;
            updPC      = 1'b0;
            mem_stage  = 1'b0;
            wr_stage   = 1'b0;
            pc_sel_vec = 1'b0;
            save_epc   = 1'b0;
            int_ack    = 1'b0;
            instr_done = 1'b0;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_ie       <= 1'b1;
            r_int_pend <= 1'b0;
            r_mem_cnt  <= 4'd0;
        end else begin
            r_state <= w_next;
            // INTR consumes the pending request but keeps one arriving in that same cycle.
            if (r_state == S_INTR)  r_int_pend <= INT;
            else if (INT)           r_int_pend <= 1'b1;
            if (r_state == S_INTR)      r_ie <= 1'b0;
            else if (w_retire && rfe)   r_ie <= 1'b1;
            if (w_mem_enter)
                r_mem_cnt <= MEM_LOAD;
            else if (r_state == S_MEM && r_mem_cnt != 4'd0)
                r_mem_cnt <= r_mem_cnt - 4'd1;
        end
    end

    assign stage = r_state;

`ifdef PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt   <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    assign cyc_cnt   = 32'h0;
    assign instr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed and randomized checks of multicycle_sequencer against a stage-list model
module tb_multicycle_sequencer;

    localparam int MW = 3;
`ifdef PERF_CNT_EN
    localparam logic [31:0] PERF_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] PERF_MASK = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        mem_access = 1'b0;
    logic        reg_write = 1'b0;
    logic        halt = 1'b0;
    logic        rfe = 1'b0;
    logic        ir_load, updPC, mem_stage, wr_stage, pc_sel_vec, save_epc, int_ack, instr_done, halted;
    logic [2:0]  stage;
    logic [31:0] cyc_cnt, instr_cnt;

    logic        rst1 = 1'b1;
    logic        ma1 = 1'b0;
    logic        rw1 = 1'b0;
    logic        zero1 = 1'b0;
    logic        b_ir_load, b_updPC, b_mem_stage, b_wr_stage, b_pc_sel_vec, b_save_epc, b_int_ack, b_instr_done, b_halted;
    logic [2:0]  b_stage;
    logic [31:0] b_cyc_cnt, b_instr_cnt;

    wire [8:0] a_strb = {ir_load, updPC, mem_stage, wr_stage, pc_sel_vec, save_epc, int_ack, instr_done, halted};
    wire [8:0] b_strb = {b_ir_load, b_updPC, b_mem_stage, b_wr_stage, b_pc_sel_vec, b_save_epc, b_int_ack, b_instr_done, b_halted};

    int total = 0;
    int bad = 0;
    bit m_ie = 1'b1;
    bit m_pend = 1'b0;
    int m_cyc = 0;
    int m_instr = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .INT(INT), .mem_access(mem_access), .reg_write(reg_write),
        .halt(halt), .rfe(rfe), .ir_load(ir_load), .updPC(updPC), .mem_stage(mem_stage),
        .wr_stage(wr_stage), .pc_sel_vec(pc_sel_vec), .save_epc(save_epc), .int_ack(int_ack),
        .instr_done(instr_done), .halted(halted), .stage(stage), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
    );

    multicycle_sequencer #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .rst(rst1), .INT(zero1), .mem_access(ma1), .reg_write(rw1),
        .halt(zero1), .rfe(zero1), .ir_load(b_ir_load), .updPC(b_updPC), .mem_stage(b_mem_stage),
        .wr_stage(b_wr_stage), .pc_sel_vec(b_pc_sel_vec), .save_epc(b_save_epc), .int_ack(b_int_ack),
        .instr_done(b_instr_done), .halted(b_halted), .stage(b_stage), .cyc_cnt(b_cyc_cnt), .instr_cnt(b_instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] strb(input bit ir, input bit upd, input bit mem, input bit wr,
                                        input bit vec, input bit epc, input bit ack, input bit done,
                                        input bit hlt);
        return {ir, upd, mem, wr, vec, epc, ack, done, hlt};
    endfunction

    task automatic chk_cnts();
        chk("cyc_cnt", cyc_cnt, 32'(m_cyc) & PERF_MASK);
        chk("instr_cnt", instr_cnt, 32'(m_instr) & PERF_MASK);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cyc   = 0;
            m_instr = 0;
        end else begin
            m_cyc++;
        end
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        INT = 1'b0;
        #1;
        chk("rst_strobes", 32'(a_strb), 32'd0);
        tick();
        rst    = 1'b0;
        m_ie   = 1'b1;
        m_pend = 1'b0;
    endtask

    task automatic intr_cycle(input bit int_in);
        mem_access = 1'b0; reg_write = 1'b0; halt = 1'b0; rfe = 1'b0; INT = int_in;
        #1;
        chk("intr_stage", 32'(stage), 32'd5);
        chk("intr_strobes", 32'(a_strb), 32'(strb(0, 1, 0, 0, 1, 1, 1, 0, 0)));
        chk_cnts();
        m_ie   = 1'b0;
        m_pend = int_in;
        tick();
    endtask

    // kind: 0 branch, 1 ALU, 2 store, 3 load; int_at/rst_at are cycle indices (-1 = never)
    task automatic do_instr(input int kind, input bit rfe_b, input int int_at, input int rst_at);
        int  st[$];
        bit  ma, rw, last, take;
        ma   = kind[1];
        rw   = kind[0];
        take = 1'b0;
        st   = {0, 1, 2};
        if (ma) repeat (MW) st.push_back(3);
        if (rw) st.push_back(4);
        for (int i = 0; i < st.size(); i++) begin
            if (i == rst_at) begin
                reset_cycle();
                return;
            end
            mem_access = ma; reg_write = rw; halt = 1'b0; rfe = rfe_b; INT = (i == int_at);
            #1;
            last = (i == st.size() - 1);
            chk($sformatf("k%0d_c%0d_stage", kind, i), 32'(stage), 32'(st[i]));
            chk($sformatf("k%0d_c%0d_strobes", kind, i), 32'(a_strb),
                32'(strb(i == 0, last, st[i] == 3, st[i] == 4, 0, 0, 0, last, 0)));
            chk_cnts();
            if (last) begin
                take = (m_pend || INT) && (m_ie || rfe_b);
                if (rfe_b) m_ie = 1'b1;
                m_instr++;
            end
            if (INT) m_pend = 1'b1;
            tick();
        end
        if (take) intr_cycle(1'b0);
    endtask

    task automatic do_halt(input int int_at);
        bit taken;
        taken = 1'b0;
        mem_access = 1'b0; reg_write = 1'b0; rfe = 1'b0; halt = 1'b1; INT = 1'b0;
        #1;
        chk("halt_fetch_stage", 32'(stage), 32'd0);
        chk("halt_fetch_strobes", 32'(a_strb), 32'(strb(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tick();
        #1;
        chk("halt_decode_stage", 32'(stage), 32'd1);
        chk("halt_decode_strobes", 32'(a_strb), 32'd0);
        tick();
        halt = 1'b0;
        for (int k = 0; k < 10 && !taken; k++) begin
            INT = (k == int_at);
            #1;
            chk("halt_stage", 32'(stage), 32'd6);
            chk("halt_strobes", 32'(a_strb), 32'(strb(0, 0, 0, 0, 0, 0, 0, 0, 1)));
            chk_cnts();
            taken = (m_pend || INT) && m_ie;
            if (INT) m_pend = 1'b1;
            tick();
        end
        if (taken) intr_cycle(1'b0);
        else       reset_cycle();
    endtask

    task automatic run1(input bit ma, input bit rw);
        int st[$];
        bit last;
        st = {0, 1, 2};
        if (ma) st.push_back(3);
        if (rw) st.push_back(4);
        for (int i = 0; i < st.size(); i++) begin
            ma1 = ma; rw1 = rw;
            #1;
            last = (i == st.size() - 1);
            chk($sformatf("mw1_c%0d_stage", i), 32'(b_stage), 32'(st[i]));
            chk($sformatf("mw1_c%0d_strobes", i), 32'(b_strb),
                32'(strb(i == 0, last, st[i] == 3, st[i] == 4, 0, 0, 0, last, 0)));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("mw1_next_stage", 32'(b_stage), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_strobes", 32'(a_strb), 32'd0);
        chk("reset_stage", 32'(stage), 32'd0);
        chk_cnts();
        tick();
        rst = 1'b0;

        do_instr(1, 0, -1, -1);
        do_instr(2, 0, -1, -1);
        do_instr(3, 0, -1, -1);
        do_instr(0, 0, -1, -1);

        do_instr(1, 0, 2, -1);
        do_instr(1, 0, 0, -1);
        do_instr(0, 1, -1, -1);
        do_instr(0, 1, -1, -1);

        do_instr(1, 0, 3, -1);
        do_instr(0, 1, -1, -1);
        do_instr(0, 1, -1, -1);

        do_halt(3);
        do_instr(0, 1, -1, -1);
        do_halt(-1);

        do_instr(3, 0, -1, 4);
        do_instr(1, 0, -1, -1);

        for (int n = 0; n < 40; n++) begin
            do_instr(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, -1);
        end

        rst1 = 1'b0;
        run1(1'b1, 1'b0);
        run1(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
